c2c_tx_framer: RTL and testbench

Chip-to-chip transmit framer sitting on the read side of the 128-bit C2C FIFO. It pops 128-bit words via the FIFO's show-ahead read port (RDEN/RDATA/EMPTY) and wraps them into packets of up to BURST_MAX words. Each packet is emitted as a 32-bit valid/ready beat stream (header, data beats, trailer) toward the C2C lane serializer. It is the consumer-side counterpart of the FIFO write port, and runs entirely in the FIFO read clock domain.

---
 rtl/c2c_tx_framer.sv | 132 +++++++++++++
 tb/tb_c2c_tx_framer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2c_tx_framer.sv
//------------------------------------------------------------------------------
// c2c_tx_framer : pops 128-bit show-ahead FIFO words, frames them as 32-bit
//                 header/data/trailer beats with valid/ready handshake.
// Revision      : 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module c2c_tx_framer #(
    parameter int BURST_MAX = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic         rden_o,
    input  logic [127:0] rdata_i,
    input  logic         empty_i,
    output logic         txvalid_o,
    input  logic         txready_i,
    output logic [31:0]  txdata_o,
    output logic         txsop_o,
    output logic         txeop_o,
    output logic         busy_o
);

    localparam logic [7:0] C_BURST_MAX = 8'(BURST_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_TRL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] w_beat_data;
    logic [7:0]  w_beat_xor;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            seq_q   <= 8'd0;
            wcnt_q  <= 8'd0;
            csum_q  <= 8'd0;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            beat_q  <= beat_d;
        end
    end

    // RDATA stays on the head word until the pop after beat 3, so no capture register.
    always_comb begin
        w_beat_data = 32'd0;
        case (beat_q)
            2'd0:    w_beat_data = rdata_i[31:0];
            2'd1:    w_beat_data = rdata_i[63:32];
            2'd2:    w_beat_data = rdata_i[95:64];
            default: w_beat_data = rdata_i[127:96];
        endcase
        w_beat_xor = w_beat_data[31:24] ^ w_beat_data[23:16]
                   ^ w_beat_data[15:8]  ^ w_beat_data[7:0];
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        wcnt_d    = wcnt_q;
        csum_d    = csum_q;
        beat_d    = beat_q;
        rden_o    = 1'b0;
        txvalid_o = 1'b0;
        txdata_o  = 32'd0;
        txsop_o   = 1'b0;
        txeop_o   = 1'b0;
        busy_o    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                wcnt_d = 8'd0;
                csum_d = 8'd0;
                if (en_i && !empty_i) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                txvalid_o = 1'b1;
                txsop_o   = 1'b1;
                txdata_o  = {16'hA5C3, seq_q, 8'h00};
                if (txready_i) begin
                    state_d = S_DATA;
                    beat_d  = 2'd0;
                end
            end
            S_DATA: begin
                // Beat 0 doubles as the continue/close decision; closing costs one bubble.
                if (beat_q == 2'd0 && (wcnt_q == C_BURST_MAX || empty_i)) begin
                    state_d = S_TRL;
                end else begin
                    txvalid_o = 1'b1;
                    txdata_o  = w_beat_data;
                    if (txready_i) begin
                        csum_d = csum_q ^ w_beat_xor;
                        beat_d = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            rden_o = 1'b1;
                            wcnt_d = wcnt_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                txvalid_o = 1'b1;
                txeop_o   = 1'b1;
                txdata_o  = {8'hE0, seq_q, wcnt_q, csum_q};
                if (txready_i) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_c2c_tx_framer.sv
//------------------------------------------------------------------------------
// tb_c2c_tx_framer : directed bench with a packet-level reference model and
//                    a show-ahead FIFO model feeding the framer.
//------------------------------------------------------------------------------
`default_nettype none

module tb_c2c_tx_framer;

    localparam int BURST_MAX = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         rden_o;
    logic [127:0] rdata_i;
    logic         empty_i;
    logic         txvalid_o;
    logic         txready_i;
    logic [31:0]  txdata_o;
    logic         txsop_o;
    logic         txeop_o;
    logic         busy_o;

    c2c_tx_framer #(.BURST_MAX(BURST_MAX)) u_dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .rden_o    (rden_o),
        .rdata_i   (rdata_i),
        .empty_i   (empty_i),
        .txvalid_o (txvalid_o),
        .txready_i (txready_i),
        .txdata_o  (txdata_o),
        .txsop_o   (txsop_o),
        .txeop_o   (txeop_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: the head moves on the same edge that samples RDEN.
    logic [127:0] mem [0:1023];
    int           wp = 0;
    int           rp = 0;
    logic         rden_s = 1'b0;

    assign rdata_i = mem[rp[9:0]];
    assign empty_i = (wp == rp);

    always @(posedge clk) begin
        if (rden_s) rp <= rp + 1;
    end

    int          vec = 0;
    int          mis = 0;
    logic [33:0] exp_q [$];
    logic [7:0]  m_seq = 8'd0;
    int          busy_cnt = 0;
    int          valid_cnt = 0;
    int          rden_cnt = 0;
    logic        stall_q = 1'b0;
    logic [33:0] stall_beat = 34'd0;
    logic [33:0] cur;
    logic [33:0] e;

    // Compare process: every accepted beat must be the next modelled beat.
    always @(negedge clk) begin
        rden_s = rden_o;
        cur    = {txsop_o, txeop_o, txdata_o};
        if (busy_o)    busy_cnt++;
        if (txvalid_o) valid_cnt++;
        if (rden_o)    rden_cnt++;
        vec++;
        if (rden_o && empty_i) begin
            mis++;
            $display("FAIL rden_empty: RDEN=1 EMPTY=1 at %0t, required no pop", $time);
        end
        if (stall_q && !rst_i) begin
            vec++;
            if (!txvalid_o || cur !== stall_beat) begin
                mis++;
                $display("FAIL hold: got valid=%0b beat=%h, required valid=1 beat=%h", txvalid_o, cur, stall_beat);
            end
        end
        if (txvalid_o && txready_i) begin
            vec++;
            if (exp_q.size() == 0) begin
                mis++;
                $display("FAIL extra_beat: got %h, required no beat", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    mis++;
                    $display("FAIL beat: got {sop,eop,data}=%h, required %h", cur, e);
                end
            end
        end
        stall_q    = txvalid_o && !txready_i;
        stall_beat = cur;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vec++;
        if (act !== exp_v) begin
            mis++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [127:0] w);
        mem[wp[9:0]] = w;
        wp++;
    endtask

    // Reference packet: header, 4 beats per word LSB first, trailer with XOR of all data bytes.
    task automatic exp_packet(input int first, input int n);
        logic [127:0] w;
        logic [31:0]  d;
        logic [7:0]   cs;
        cs = 8'd0;
        exp_q.push_back({2'b10, 16'hA5C3, m_seq, 8'h00});
        for (int i = 0; i < n; i++) begin
            w = mem[(first + i) % 1024];
            for (int b = 0; b < 4; b++) begin
                d  = w[32*b +: 32];
                cs = cs ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
                exp_q.push_back({2'b00, d});
            end
        end
        exp_q.push_back({2'b01, 8'hE0, m_seq, n[7:0], cs});
        m_seq = m_seq + 8'd1;
    endtask

    task automatic run(input int budget, input bit rnd);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            txready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_q.size() == 0 && !busy_o) break;
        end
        if (i == budget) begin
            vec++;
            mis++;
            $display("FAIL timeout: got %0d beats outstanding after %0d cycles, required 0", exp_q.size(), budget);
        end
        txready_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_seq = 8'd0;
    endtask

    logic [33:0] lit [0:5];
    int b0, r0, v0, base;

    initial begin
        lit[0] = {2'b10, 32'hA5C30000};
        lit[1] = {2'b00, 32'h03020100};
        lit[2] = {2'b00, 32'h07060504};
        lit[3] = {2'b00, 32'h0B0A0908};
        lit[4] = {2'b00, 32'h0F0E0D0C};
        lit[5] = {2'b01, 32'hE0000100};

        rst_i = 1'b1; en_i = 1'b0; txready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rden_o, txvalid_o, txdata_o, txsop_o, txeop_o, busy_o}, 64'd0);
        rst_i = 1'b0;

        // Single word: model pinned against hand-computed beats.
        push(128'h0F0E0D0C_0B0A0908_07060504_03020100);
        exp_packet(0, 1);
        for (int k = 0; k < 6; k++) chk("model_pin", exp_q[k], lit[k]);
        b0 = busy_cnt; r0 = rden_cnt;
        en_i = 1'b1;
        @(posedge clk); #1;
        chk("hdr_latency", {txvalid_o, txsop_o, txdata_o}, {2'b11, 32'hA5C30000});
        run(50, 1'b0);
        en_i = 1'b0;
        chk("single_cycles", busy_cnt - b0, 7);
        chk("single_rden", rden_cnt - r0, 1);
        chk("single_empty", empty_i, 1);

        // Burst split 8/8/4 with EN held.
        base = wp;
        for (int i = 0; i < 20; i++) push({$urandom(), $urandom(), $urandom(), $urandom()});
        exp_packet(base, 8);
        exp_packet(base + 8, 8);
        exp_packet(base + 16, 4);
        b0 = busy_cnt; r0 = rden_cnt;
        en_i = 1'b1;
        run(300, 1'b0);
        en_i = 1'b0;
        chk("burst_cycles", busy_cnt - b0, 89);
        chk("burst_rden", rden_cnt - r0, 20);
        chk("burst_empty", empty_i, 1);

        // Backpressure on a 3-word packet.
        base = wp;
        for (int i = 0; i < 3; i++) push({$urandom(), $urandom(), $urandom(), $urandom()});
        exp_packet(base, 3);
        r0 = rden_cnt;
        en_i = 1'b1;
        run(400, 1'b1);
        en_i = 1'b0;
        chk("bp_rden", rden_cnt - r0, 3);

        // Underrun: packet closes at 2 words, later words form the next packet.
        base = wp;
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        exp_packet(base, 2);
        b0 = busy_cnt;
        en_i = 1'b1;
        run(100, 1'b0);
        chk("underrun_cycles", busy_cnt - b0, 11);
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        exp_packet(base + 2, 2);
        run(100, 1'b0);
        en_i = 1'b0;

        // Sequence wrap: 257 single-word packets from seq 0.
        do_reset();
        en_i = 1'b1;
        for (int p = 0; p < 257; p++) begin
            base = wp;
            push({$urandom(), $urandom(), $urandom(), $urandom()});
            exp_packet(base, 1);
            run(50, 1'b0);
        end
        en_i = 1'b0;

        // EN low with data waiting: nothing moves.
        base = wp;
        push(128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
        push({$urandom(), $urandom(), $urandom(), $urandom()});
        v0 = valid_cnt; r0 = rden_cnt; b0 = busy_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("en0_valid", valid_cnt - v0, 0);
        chk("en0_rden", rden_cnt - r0, 0);
        chk("en0_busy", busy_cnt - b0, 0);

        // Reset during data beat 2 of the first word.
        exp_q.push_back({2'b10, 16'hA5C3, m_seq, 8'h00});
        exp_q.push_back({2'b00, 32'hAAAA0000});
        exp_q.push_back({2'b00, 32'hBBBB0001});
        exp_q.push_back({2'b00, 32'hCCCC0002});
        en_i = 1'b1;
        begin : wait_beat2
            int i;
            for (i = 0; i < 50; i++) begin
                @(posedge clk); #1;
                if (txvalid_o && txdata_o == 32'hCCCC0002) break;
            end
            chk("beat2_reached", (i < 50), 1);
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs", {rden_o, txvalid_o, txdata_o, txsop_o, txeop_o, busy_o}, 64'd0);
        chk("rst_partial", exp_q.size(), 0);
        rst_i = 1'b0;
        m_seq = 8'd0;
        exp_packet(base, 2);
        chk("rst_hdr_pin", exp_q[0], {2'b10, 32'hA5C30000});
        r0 = rden_cnt;
        run(100, 1'b0);
        en_i = 1'b0;
        chk("rst_rden", rden_cnt - r0, 2);
        chk("rst_empty", empty_i, 1);

        chk("exp_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

`default_nettype wire
